// File: rtl/aes_shift_rows_pipe.sv
// aes_shift_rows_pipe: Rijndael ShiftRows / InvShiftRows for Nb = 4, 6 or 8 columns,
// followed by an elastic valid/ready register pipeline that carries a sideband tag.
module aes_shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_inv,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic [32*NB-1:0]    state_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAG_W-1:0]    out_tag,
  output logic [32*NB-1:0]    state_out
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("aes_shift_rows_pipe: STAGES must be in 1..4");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_shift_rows_pipe: TAG_W must be at least 1");
  end

  // Rijndael row offsets: the wide 256-bit block pushes rows 2 and 3 one column further.
  function automatic int row_shift(input int r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  logic [W-1:0]       perm;
  logic [STAGES-1:0]  valid_q;
  logic [TAG_W-1:0]   tag_q   [STAGES];
  logic [W-1:0]       data_q  [STAGES];
  logic [STAGES-1:0]  rdy;
  logic [STAGES-1:0]  up_valid;
  logic [TAG_W-1:0]   up_tag  [STAGES];
  logic [W-1:0]       up_data [STAGES];

  // Byte (r,c) sits at index 4c+r counted from the MSB; pull each one from its rotated source column.
  always_comb begin
    perm = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (in_inv)
          perm[W-1-8*(4*c+r) -: 8] = state_in[W-1-8*(4*((c + NB - row_shift(r)) % NB) + r) -: 8];
        else
          perm[W-1-8*(4*c+r) -: 8] = state_in[W-1-8*(4*((c + row_shift(r)) % NB) + r) -: 8];
      end
    end
  end

  // A stage can load when it or any stage after it has a hole, or the consumer is taking a block;
  // written in closed form so the ready chain never feeds back on itself.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < STAGES; i++) begin
      rdy[i] = out_ready;
      for (int j = i; j < STAGES; j++) begin
        if (!valid_q[j]) rdy[i] = 1'b1;
      end
    end
  end

  // Each stage's upstream source: the permuted input for stage 0, otherwise the previous register.
  always_comb begin
    up_valid[0] = in_valid;
    up_tag[0]   = in_tag;
    up_data[0]  = perm;
    for (int i = 1; i < STAGES; i++) begin
      up_valid[i] = valid_q[i-1];
      up_tag[i]   = tag_q[i-1];
      up_data[i]  = data_q[i-1];
    end
  end

  // Advance every ready stage; payload only updates on a real block so an empty output keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (rdy[i]) begin
          valid_q[i] <= up_valid[i];
          if (up_valid[i]) begin
            tag_q[i]  <= up_tag[i];
            data_q[i] <= up_data[i];
          end
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign state_out = data_q[STAGES-1];

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// tb_aes_shift_rows_pipe: scoreboard bench over four configurations of aes_shift_rows_pipe.
module tb_aes_shift_rows_pipe;

  localparam int TAG_W = 4;
  localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_inv = 1'b0;
  logic             out_ready = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [255:0]     din = '0;
  int               sel = 0;

  logic ir_a, ov_a, ir_b, ov_b, ir_c, ov_c, ir_d, ov_d;
  logic [TAG_W-1:0] ot_a, ot_b, ot_c, ot_d;
  logic [127:0] so_a, so_d;
  logic [255:0] so_b;
  logic [191:0] so_c;

  logic             obs_ir, obs_ov;
  logic [TAG_W-1:0] obs_ot;
  logic [255:0]     obs_so;

  typedef struct {
    logic [255:0]     data;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t sb[$];

  int compared = 0;
  int mismatched = 0;
  int popped = 0;
  bit last_in_ready = 1'b0;
  bit prev_stall = 1'b0;
  logic prev_ov;
  logic [TAG_W-1:0] prev_ot;
  logic [255:0] prev_so;

  always #5 clk = ~clk;

  aes_shift_rows_pipe #(.NB(4), .STAGES(1), .TAG_W(TAG_W)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(ir_a), .in_inv(in_inv),
    .in_tag(in_tag), .state_in(din[127:0]), .out_valid(ov_a), .out_ready(out_ready),
    .out_tag(ot_a), .state_out(so_a));
  aes_shift_rows_pipe #(.NB(8), .STAGES(2), .TAG_W(TAG_W)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(ir_b), .in_inv(in_inv),
    .in_tag(in_tag), .state_in(din), .out_valid(ov_b), .out_ready(out_ready),
    .out_tag(ot_b), .state_out(so_b));
  aes_shift_rows_pipe #(.NB(6), .STAGES(4), .TAG_W(TAG_W)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(ir_c), .in_inv(in_inv),
    .in_tag(in_tag), .state_in(din[191:0]), .out_valid(ov_c), .out_ready(out_ready),
    .out_tag(ot_c), .state_out(so_c));
  aes_shift_rows_pipe #(.NB(4), .STAGES(3), .TAG_W(TAG_W)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 3), .in_ready(ir_d), .in_inv(in_inv),
    .in_tag(in_tag), .state_in(din[127:0]), .out_valid(ov_d), .out_ready(out_ready),
    .out_tag(ot_d), .state_out(so_d));

  // Present the selected instance's outputs, zero-extended to the widest state.
  always_comb begin
    obs_ir = ir_a; obs_ov = ov_a; obs_ot = ot_a; obs_so = {128'b0, so_a};
    case (sel)
      1: begin obs_ir = ir_b; obs_ov = ov_b; obs_ot = ot_b; obs_so = so_b; end
      2: begin obs_ir = ir_c; obs_ov = ov_c; obs_ot = ot_c; obs_so = {64'b0, so_c}; end
      3: begin obs_ir = ir_d; obs_ov = ov_d; obs_ot = ot_d; obs_so = {128'b0, so_d}; end
      default: ;
    endcase
  end

  function automatic int cur_nb();
    case (sel)
      1: return 8;
      2: return 6;
      default: return 4;
    endcase
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference permutation straight from the row/column definition; result occupies the low 32*nb bits.
  function automatic logic [255:0] model(input logic [255:0] s, input int nb, input bit inv);
    logic [255:0] o;
    int sh[4];
    int src;
    o = '0;
    sh = '{0, 1, 2, 3};
    if (nb == 8) sh = '{0, 1, 3, 4};
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - sh[r] + nb) % nb : (c + sh[r]) % nb;
        o[32*nb-1-8*(4*c+r) -: 8] = s[32*nb-1-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction

  // One clock cycle: drive at negedge, sample mid-cycle, score handshakes, return at posedge.
  task automatic cycle(input bit v, input bit r, input logic [255:0] d, input bit inv,
                       input logic [TAG_W-1:0] tag);
    exp_t e;
    @(negedge clk);
    in_valid = v; out_ready = r; din = d; in_inv = inv; in_tag = tag;
    #2;
    last_in_ready = obs_ir;
    if (prev_stall) begin
      compared++;
      if ({obs_ov, obs_ot, obs_so} !== {prev_ov, prev_ot, prev_so}) begin
        mismatched++;
        $display("[TB] FAIL stall_hold: got v=%b tag=%h data=%h, want v=%b tag=%h data=%h",
                 obs_ov, obs_ot, obs_so, prev_ov, prev_ot, prev_so);
      end
    end
    prev_stall = obs_ov && !r;
    prev_ov = obs_ov; prev_ot = obs_ot; prev_so = obs_so;
    if (obs_ov && r) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_output: got tag=%h data=%h, want no block", obs_ot, obs_so);
      end else begin
        e = sb.pop_front();
        popped++;
        if ({obs_ot, obs_so} !== {e.tag, e.data}) begin
          mismatched++;
          $display("[TB] FAIL scoreboard: got tag=%h data=%h, want tag=%h data=%h",
                   obs_ot, obs_so, e.tag, e.data);
        end
      end
    end
    if (v && obs_ir) begin
      e.data = model(d, cur_nb(), inv);
      e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 50) begin
      cycle(1'b0, 1'b1, rand256(), 1'b0, 4'(n));
      n++;
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain_timeout: got %0d blocks outstanding, want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; prev_stall = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 4; s++) begin
      sel = s; #1;
      compared += 3;
      if (obs_ov !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid[%0d]: got %b want 0", s, obs_ov); end
      if (obs_so !== '0) begin mismatched++; $display("[TB] FAIL reset_state[%0d]: got %h want 0", s, obs_so); end
      if (obs_ot !== '0) begin mismatched++; $display("[TB] FAIL reset_tag[%0d]: got %h want 0", s, obs_ot); end
    end
    @(negedge clk); rst = 1'b0; sel = 0;
    @(posedge clk); #1;
    for (int s = 0; s < 4; s++) begin
      sel = s; #1;
      compared++;
      if (obs_ir !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready[%0d]: got %b want 1", s, obs_ir); end
    end
    sel = 0;
  endtask

  task automatic test_fips();
    sel = 0;
    cycle(1'b1, 1'b0, {128'b0, FIPS_IN}, 1'b0, 4'd3);
    #1;
    compared += 2;
    if (obs_ov !== 1'b1 || obs_ot !== 4'd3) begin
      mismatched++; $display("[TB] FAIL fips_fwd_tag: got v=%b tag=%h want v=1 tag=3", obs_ov, obs_ot);
    end
    if (obs_so[127:0] !== FIPS_OUT) begin
      mismatched++; $display("[TB] FAIL fips_fwd: got %h want %h", obs_so[127:0], FIPS_OUT);
    end
    cycle(1'b1, 1'b1, {128'b0, FIPS_OUT}, 1'b1, 4'd5);
    cycle(1'b0, 1'b0, '0, 1'b0, 4'd0);
    #1;
    compared++;
    if (obs_so[127:0] !== FIPS_IN || obs_ot !== 4'd5) begin
      mismatched++; $display("[TB] FAIL fips_inv: got tag=%h data=%h want tag=5 data=%h", obs_ot, obs_so[127:0], FIPS_IN);
    end
    drain();
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, rand256(), i[0], 4'(i));
    drain();
  endtask

  task automatic test_nb8_nb6();
    logic [255:0] d, fwd;
    sel = 1;
    for (int k = 0; k < 32; k++) d[255-8*k -: 8] = 8'(k);
    cycle(1'b1, 1'b0, d, 1'b0, 4'd1);
    cycle(1'b0, 1'b0, '0, 1'b0, 4'd0);
    #1;
    compared++;
    if (obs_ov !== 1'b1 || obs_so[255 -: 32] !== 32'h00050e13) begin
      mismatched++; $display("[TB] FAIL nb8_col0: got v=%b col0=%h want v=1 col0=00050e13", obs_ov, obs_so[255 -: 32]);
    end
    fwd = obs_so;
    drain();
    cycle(1'b1, 1'b0, fwd, 1'b1, 4'd2);
    cycle(1'b0, 1'b0, '0, 1'b0, 4'd0);
    #1;
    compared++;
    if (obs_so !== d) begin
      mismatched++; $display("[TB] FAIL nb8_inverse: got %h want %h", obs_so, d);
    end
    drain();
    sel = 2;
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, rand256(), i[0], 4'(i));
    drain();
  endtask

  task automatic test_back_to_back_stall();
    int sent = 0;
    int start = popped;
    bit v, r;
    sel = 3;
    for (int cyc = 0; cyc < 60 && (sent < 10 || sb.size() > 0); cyc++) begin
      v = sent < 10;
      r = !(cyc >= 4 && cyc <= 7);
      cycle(v, r, rand256(), cyc[0], 4'(sent));
      if (v && last_in_ready) sent++;
      if (cyc >= 4 && cyc <= 7) begin
        compared++;
        if (last_in_ready !== 1'b0) begin
          mismatched++; $display("[TB] FAIL full_in_ready cyc%0d: got %b want 0", cyc, last_in_ready);
        end
      end
    end
    compared++;
    if (popped - start != 10 || sb.size() != 0) begin
      mismatched++; $display("[TB] FAIL stall_count: got %0d out, %0d pending, want 10 out, 0 pending", popped - start, sb.size());
    end
  endtask

  task automatic test_reset_in_flight();
    sel = 1;
    cycle(1'b1, 1'b0, rand256(), 1'b0, 4'd7);
    cycle(1'b1, 1'b0, rand256(), 1'b1, 4'd8);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; din = rand256();
    @(posedge clk); #1;
    compared++;
    if (obs_ov !== 1'b0 || obs_so !== '0 || obs_ot !== '0) begin
      mismatched++; $display("[TB] FAIL mid_reset: got v=%b tag=%h data=%h want all 0", obs_ov, obs_ot, obs_so);
    end
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, rand256(), 1'b0, 4'd0);
    #1;
    compared++;
    if (obs_ov !== 1'b0) begin
      mismatched++; $display("[TB] FAIL stale_block: got out_valid=%b want 0", obs_ov);
    end
  endtask

  task automatic test_random();
    localparam int N = 3000;
    int sent, cyc, start;
    bit v, r;
    for (int s = 0; s < 3; s++) begin
      sel = s; sent = 0; cyc = 0; start = popped;
      while ((sent < N || sb.size() > 0) && cyc < 4 * N + 100) begin
        v = (sent < N) && ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 3) != 0;
        cycle(v, r, rand256(), 1'($urandom), 4'($urandom));
        if (v && last_in_ready) sent++;
        cyc++;
      end
      compared++;
      if (sent != N || sb.size() != 0 || popped - start != N) begin
        mismatched++;
        $display("[TB] FAIL random_nb%0d: got sent=%0d out=%0d pending=%0d want %0d/%0d/0",
                 cur_nb(), sent, popped - start, sb.size(), N, N);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_nb8_nb6();
    test_back_to_back_stall();
    test_reset_in_flight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
